pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage RV32 core: drives the stall, flush and bubble controls
//  around the IF/ID and ID/EX registers that feed pipeline_decode. Handles three cases: load-use hazards
//  (bubble insertion), taken branch/jump redirects (flush), and data-memory wait (global freeze).
//  Also keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  LOAD_STALLS  1   bubbles inserted per load-use hazard (legal 1..3)
//  FLUSH_CYCLES 1   cycles IF/ID flush and ID/EX bubble are held after a redirect (legal 1..3)
//  CNT_W        32  width of stall_count_o
// PORTS
//  clk_i          in   1      clock, all state on rising edge
//  rst_ni         in   1      asynchronous reset, active-low
//  id_valid_i     in   1      ID stage holds a valid instruction
//  id_rs1_i       in   5      rs1 address decoded in ID
//  id_rs2_i       in   5      rs2 address decoded in ID
//  id_use_rs1_i   in   1      ID instruction reads rs1
//  id_use_rs2_i   in   1      ID instruction reads rs2
//  ex_valid_i     in   1      EX stage holds a valid instruction
//  ex_mem_read_i  in   1      EX instruction is a LOAD
//  ex_rd_i        in   5      EX destination register
//  redirect_i     in   1      EX resolved taken branch/JAL/JALR this cycle
//  mem_busy_i     in   1      data memory not ready; pipeline must freeze
//  pc_stall_o     out  1      hold PC
//  ifid_stall_o   out  1      hold IF/ID register
//  ifid_flush_o   out  1      clear IF/ID register to NOP
//  idex_bubble_o  out  1      load NOP into ID/EX
//  back_freeze_o  out  1      hold ID/EX, EX/MEM, MEM/WB registers
//  state_o        out  2      FSM state: 0 RUN, 1 LOAD_STALL, 2 FLUSH
//  stall_count_o  out  CNT_W  cycles in which pc_stall_o was asserted, saturating
// BEHAVIOUR
//  - Reset (rst_ni=0, async): state=RUN, cnt=0, stall_count_o=0; all control outputs forced to 0 while in reset.
//  - hazard = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rd_i!=0) &
//    ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
//  - Control outputs are combinational from state and inputs (same-cycle effect). state/cnt/counter are registered.
//  - Per-cycle priority: mem_busy_i > redirect_i > current stall state > hazard.
//  - mem_busy_i=1, any state: pc_stall, ifid_stall, back_freeze=1; flush=bubble=0; state and cnt hold.
//    A redirect_i or hazard seen during a freeze is ignored. EX re-presents it after the freeze ends.
//  - RUN: if redirect_i: ifid_flush=idex_bubble=1. Next state is FLUSH with cnt=FLUSH_CYCLES-1 when
//    FLUSH_CYCLES>1, otherwise RUN.
//    Else if hazard: pc_stall=ifid_stall=idex_bubble=1. Next state is LOAD_STALL with cnt=LOAD_STALLS-1
//    when LOAD_STALLS>1, otherwise RUN.
//    Else all controls are 0.
//  - LOAD_STALL: pc_stall=ifid_stall=idex_bubble=1 and cnt decrements; cnt==1 -> RUN next cycle.
//    A redirect_i in this state overrides: the flush outputs are applied instead of the stall, and the FSM
//    follows the RUN redirect transition.
//  - FLUSH: ifid_flush=idex_bubble=1 and cnt decrements; cnt==1 -> RUN. redirect_i reloads cnt=FLUSH_CYCLES-1.
//  - ifid_flush_o and ifid_stall_o are never both 1. Flush wins.
//  - Encoding 3 is illegal and returns to RUN on the next edge with all controls 0.
//  - stall_count_o increments by 1 on each edge where pc_stall_o=1 and holds at 2^CNT_W-1 (no wrap).
// TESTING
//  1 Load-use: ex lw x5 (rd=5, mem_read=1), id add uses rs1=5 -> 1 cycle pc_stall/ifid_stall/idex_bubble=1, then 0; stall_count_o=1.
//  2 x0 / no-use: ex_rd_i=0, or id_use_rs2_i=0 with rs2 match -> no stall for any cycle.
//  3 Redirect with FLUSH_CYCLES=2 -> ifid_flush=idex_bubble=1 for exactly 2 cycles; state_o 0->2->0.
//  4 mem_busy_i held 3 cycles during LOAD_STALL (LOAD_STALLS=2, cnt=1) -> freeze 3 cycles with state held; then 1 stall cycle; stall_count_o=5.
//  5 Hazard and redirect_i in the same cycle -> flush only, pc_stall_o=0; rst_ni low mid-FLUSH -> outputs 0 immediately, state_o=0.
//  6 CNT_W=4, 20 consecutive stall cycles -> stall_count_o stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core.
// Drives stall/flush/bubble controls around IF/ID and ID/EX for load-use hazards,
// taken redirects and data-memory wait, and counts stalled cycles (saturating).
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_STALLS  = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             redirect_i,
  input  logic             mem_busy_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             back_freeze_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_count_o
);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StFlush     = 2'd2,
    StIllegal   = 2'd3
  } state_e;

  localparam logic [1:0] LoadReload  = 2'(LOAD_STALLS - 1);
  localparam logic [1:0] FlushReload = 2'(FLUSH_CYCLES - 1);
  localparam bit         LoadMulti   = (LOAD_STALLS > 1);
  localparam bit         FlushMulti  = (FLUSH_CYCLES > 1);

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hazard;
  logic             pc_stall, ifid_stall, ifid_flush, idex_bubble, back_freeze;

  // Load in EX writes a register the ID instruction actually reads.
  always_comb begin
    hazard = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) &
             ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) | (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
  end

  // Next-state and raw control decode; priority freeze > redirect > stall state > hazard.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    back_freeze = 1'b0;
    if (mem_busy_i) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      back_freeze = 1'b1;
    end else if (redirect_i && (state_q != StIllegal)) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = FlushMulti ? StFlush : StRun;
      cnt_d       = FlushReload;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hazard) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = LoadMulti ? StLoadStall : StRun;
            cnt_d       = LoadReload;
          end
        end
        StLoadStall: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) state_d = StRun;
        end
        StFlush: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) state_d = StRun;
        end
        StIllegal: begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State, sequencing counter and performance counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      cnt_q       <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Controls are forced low for as long as reset is held.
  always_comb begin
    pc_stall_o    = pc_stall & rst_ni;
    ifid_stall_o  = ifid_stall & ~ifid_flush & rst_ni;
    ifid_flush_o  = ifid_flush & rst_ni;
    idex_bubble_o = idex_bubble & rst_ni;
    back_freeze_o = back_freeze & rst_ni;
    state_o       = state_q;
    stall_count_o = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (1/1/32 and 2/2/4) share the stimulus.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_mem_read, redirect, mem_busy;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic ps0, is0, fl0, bb0, bf0, ps1, is1, fl1, bb1, bf1;
  logic [1:0]  st0, st1;
  logic [31:0] cn0;
  logic [3:0]  cn1;

  int total = 0;
  int bad   = 0;

  // Model state: remaining forced cycles rather than an FSM encoding.
  int              flush_left[2];
  int              stall_left[2];
  longint unsigned m_cnt[2];
  int              ls_p[2]  = '{1, 2};
  int              fc_p[2]  = '{1, 2};
  longint unsigned cmax[2]  = '{64'hFFFF_FFFF, 64'd15};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_STALLS(1), .FLUSH_CYCLES(1), .CNT_W(32)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .ex_valid_i(ex_valid),
    .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_rd), .redirect_i(redirect), .mem_busy_i(mem_busy),
    .pc_stall_o(ps0), .ifid_stall_o(is0), .ifid_flush_o(fl0), .idex_bubble_o(bb0),
    .back_freeze_o(bf0), .state_o(st0), .stall_count_o(cn0)
  );

  pipeline_hazard_ctrl #(.LOAD_STALLS(2), .FLUSH_CYCLES(2), .CNT_W(4)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .ex_valid_i(ex_valid),
    .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_rd), .redirect_i(redirect), .mem_busy_i(mem_busy),
    .pc_stall_o(ps1), .ifid_stall_o(is1), .ifid_flush_o(fl1), .idex_bubble_o(bb1),
    .back_freeze_o(bf1), .state_o(st1), .stall_count_o(cn1)
  );

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the remaining-cycle model, then advance it one cycle.
  task automatic model_check(input int k, input logic ps, input logic is, input logic fl,
                             input logic bb, input logic bf, input logic [1:0] st,
                             input longint unsigned cnt);
    logic e_ps, e_is, e_fl, e_bb, e_bf, reads, load_use;
    int   e_st;
    e_ps = 0; e_is = 0; e_fl = 0; e_bb = 0; e_bf = 0;
    if (!rst_n) begin
      flush_left[k] = 0; stall_left[k] = 0; m_cnt[k] = 0; e_st = 0;
    end else begin
      e_st = (flush_left[k] > 0) ? 2 : (stall_left[k] > 0) ? 1 : 0;
      reads    = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
      load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != 0) && reads;
      if (mem_busy) begin
        e_ps = 1; e_is = 1; e_bf = 1;
      end else if (redirect) begin
        e_fl = 1; e_bb = 1; flush_left[k] = fc_p[k] - 1; stall_left[k] = 0;
      end else if (flush_left[k] > 0) begin
        e_fl = 1; e_bb = 1; flush_left[k]--;
      end else if (stall_left[k] > 0) begin
        e_ps = 1; e_is = 1; e_bb = 1; stall_left[k]--;
      end else if (load_use) begin
        e_ps = 1; e_is = 1; e_bb = 1; stall_left[k] = ls_p[k] - 1;
      end
    end
    chk($sformatf("u%0d.state", k), st, e_st);
    chk($sformatf("u%0d.count", k), cnt, m_cnt[k]);
    chk($sformatf("u%0d.pc_stall", k), ps, e_ps);
    chk($sformatf("u%0d.ifid_stall", k), is, e_is);
    chk($sformatf("u%0d.ifid_flush", k), fl, e_fl);
    chk($sformatf("u%0d.idex_bubble", k), bb, e_bb);
    chk($sformatf("u%0d.back_freeze", k), bf, e_bf);
    if (rst_n && e_ps && m_cnt[k] < cmax[k]) m_cnt[k]++;
  endtask

  always @(negedge clk) begin
    model_check(0, ps0, is0, fl0, bb0, bf0, st0, 64'(cn0));
    model_check(1, ps1, is1, fl1, bb1, bf1, st1, 64'(cn1));
  end

  task automatic drive(input logic idv, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic exv, input logic mr,
                       input logic [4:0] rd, input logic rdr, input logic busy);
    id_valid = idv; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_valid = exv; ex_mem_read = mr; ex_rd = rd; redirect = rdr; mem_busy = busy;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 0;
    idle();
    tick();
    rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    idle();
    redirect = 1;
    mem_busy = 1;
    tick();
    #1;
    chk("reset.flush_gated", fl0, 0);
    chk("reset.stall_gated", ps1, 0);
    chk("reset.count", cn0, 0);
    tick();
    rst_n = 1;
    idle();

    // Load-use on rs1: one bubble for u0, two for u1.
    reset_pulse();
    drive(1, 5, 7, 1, 1, 1, 1, 5, 0, 0); #1;
    chk("t1.u0.pc_stall", ps0, 1);
    chk("t1.u1.ifid_stall", is1, 1);
    chk("t1.u0.bubble", bb0, 1);
    tick();
    drive(1, 5, 7, 1, 1, 0, 0, 0, 0, 0); #1;
    chk("t1.u0.released", ps0, 0);
    chk("t1.u0.count", cn0, 1);
    chk("t1.u1.second", ps1, 1);
    chk("t1.u1.state", st1, 1);
    tick();
    idle(); #1;
    chk("t1.u1.count", cn1, 2);
    chk("t1.u1.released", ps1, 0);
    tick();

    // x0 destination and unused rs2 never stall.
    drive(1, 0, 0, 1, 1, 1, 1, 0, 0, 0); #1;
    chk("t2.x0", ps1, 0);
    tick();
    drive(1, 3, 9, 1, 0, 1, 1, 9, 0, 0); #1;
    chk("t2.nouse", ps0, 0);
    tick();
    drive(1, 3, 9, 0, 1, 1, 1, 9, 0, 0); #1;
    chk("t2.rs2use", ps0, 1);
    tick();

    // Redirect: flush held 2 cycles on u1, then a reload while in FLUSH.
    reset_pulse();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
    chk("t3.a.flush", fl1, 1);
    chk("t3.a.state", st1, 0);
    tick();
    idle(); #1;
    chk("t3.b.flush", fl1, 1);
    chk("t3.b.state", st1, 2);
    chk("t3.b.u0", fl0, 0);
    tick();
    #1;
    chk("t3.c.flush", fl1, 0);
    chk("t3.c.state", st1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
    chk("t3.reload.flush", fl1, 1);
    tick();
    idle(); #1;
    chk("t3.reload.state", st1, 2);
    tick();
    #1;
    chk("t3.reload.done", fl1, 0);

    // Freeze during LOAD_STALL holds state, then the remaining stall cycle.
    reset_pulse();
    drive(1, 5, 7, 1, 1, 1, 1, 5, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 7, 1, 1, 0, 0, 0, 0, 1); #1;
      chk("t4.freeze.state", st1, 1);
      chk("t4.freeze.bf", bf1, 1);
      chk("t4.freeze.bubble", bb1, 0);
      tick();
    end
    drive(1, 5, 7, 1, 1, 0, 0, 0, 0, 0); #1;
    chk("t4.resume", ps1, 1);
    tick();
    idle(); #1;
    chk("t4.u1.count", cn1, 5);
    chk("t4.u1.state", st1, 0);
    chk("t4.u0.count", cn0, 4);
    tick();

    // Hazard and redirect together, then reset mid-FLUSH.
    reset_pulse();
    drive(1, 5, 7, 1, 1, 1, 1, 5, 1, 0); #1;
    chk("t5.flush", fl1, 1);
    chk("t5.pc_stall", ps1, 0);
    chk("t5.ifid_stall", is0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
    chk("t5.inflush", st1, 2);
    rst_n = 0; #1;
    chk("t5.rst.flush", fl1, 0);
    chk("t5.rst.bubble", bb1, 0);
    chk("t5.rst.state", st1, 0);
    tick();
    rst_n = 1;
    idle();

    // 20 frozen cycles: the 4-bit counter saturates at 15.
    reset_pulse();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (20) tick();
    idle(); #1;
    chk("t6.u1.sat", cn1, 15);
    chk("t6.u0.count", cn0, 20);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
